// File: rtl/run_before_decoder_if.sv
// Handshake and bit-window bundle between the total_zeros stage, the run_before decoder and its consumers.
// No logic, wiring only.
// The slave side (the decoder) drives the run outputs, and the master side drives the block inputs and RunReady.
interface run_before_decoder_if #(
  parameter int CW = 5
);
  logic          Start;
  logic [CW-1:0] TotalCoeff;
  logic [3:0]    TotalZeros;
  logic [10:0]   Bits;
  logic          RunValid;
  logic          RunReady;
  logic [3:0]    RunBefore;
  logic [CW-1:0] CoeffIdx;
  logic          ShiftEn;
  logic [3:0]    NumShift;
  logic          Busy;
  logic          Done;
  logic          Error;

  modport master (
    output Start, TotalCoeff, TotalZeros, Bits, RunReady,
    input  RunValid, RunBefore, CoeffIdx, ShiftEn, NumShift, Busy, Done, Error
  );

  modport slave (
    input  Start, TotalCoeff, TotalZeros, Bits, RunReady,
    output RunValid, RunBefore, CoeffIdx, ShiftEn, NumShift, Busy, Done, Error
  );
endinterface

// File: rtl/run_before_decoder.sv
// CAVLC run_before decoder: emits one zero-run per coefficient, in reverse scan order, for one residual block.
// Latency: the first run is valid one cycle after Start, then one run per cycle while RunReady stays high.
// Backpressure: RunValid and its payload are held while RunReady is low, and ShiftEn fires only on accept.
module run_before_decoder #(
  parameter int MAX_COEFF = 16,
  parameter int CW        = 5
) (
  input  logic                 Clk,
  input  logic                 nReset,
  run_before_decoder_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]    state_q;
  logic [CW-1:0] tc_q;
  logic [3:0]    zl_q;
  logic [CW-1:0] idx_q;

  logic [2:0]    zl_sat;
  logic [3:0]    dec_run;
  logic [3:0]    dec_ns;
  logic          dec_bad;
  logic          lz_found;

  logic          last_c;
  logic [3:0]    run_c;
  logic [3:0]    ns_c;
  logic          err_c;
  logic          accept_c;
  logic          tc_big;
  logic          tz_big;

  assign last_c = (idx_q == (tc_q - ONE));
  assign zl_sat = (zl_q > 4'd7) ? 3'd7 : zl_q[2:0];

  // Table decode of run_before from the head of the bit window, indexed by min(ZerosLeft,7)
  always_comb begin
    dec_run  = 4'd0;
    dec_ns   = 4'd0;
    dec_bad  = 1'b0;
    lz_found = 1'b0;
    case (zl_sat)
      3'd1: begin
        dec_ns  = 4'd1;
        dec_run = bus.Bits[10] ? 4'd0 : 4'd1;
      end
      3'd2: begin
        if (bus.Bits[10]) begin
          dec_ns  = 4'd1;
          dec_run = 4'd0;
        end else begin
          dec_ns  = 4'd2;
          dec_run = bus.Bits[9] ? 4'd1 : 4'd2;
        end
      end
      3'd3: begin
        dec_ns  = 4'd2;
        dec_run = 4'd3 - {2'b00, bus.Bits[10:9]};
      end
      3'd4: begin
        if (bus.Bits[10:9] != 2'b00) begin
          dec_ns  = 4'd2;
          dec_run = 4'd3 - {2'b00, bus.Bits[10:9]};
        end else begin
          dec_ns  = 4'd3;
          dec_run = bus.Bits[8] ? 4'd3 : 4'd4;
        end
      end
      3'd5: begin
        if (bus.Bits[10]) begin
          dec_ns  = 4'd2;
          dec_run = bus.Bits[9] ? 4'd0 : 4'd1;
        end else begin
          dec_ns  = 4'd3;
          dec_run = 4'd5 - {2'b00, bus.Bits[9:8]};
        end
      end
      3'd6: begin
        if (bus.Bits[10:9] == 2'b11) begin
          dec_ns  = 4'd2;
          dec_run = 4'd0;
        end else begin
          dec_ns = 4'd3;
          case (bus.Bits[10:8])
            3'b000:  dec_run = 4'd1;
            3'b001:  dec_run = 4'd2;
            3'b011:  dec_run = 4'd3;
            3'b010:  dec_run = 4'd4;
            3'b101:  dec_run = 4'd5;
            3'b100:  dec_run = 4'd6;
            default: dec_run = 4'd0;
          endcase
        end
      end
      3'd7: begin
        if (bus.Bits[10:8] != 3'b000) begin
          dec_ns  = 4'd3;
          dec_run = 4'd7 - {1'b0, bus.Bits[10:8]};
        end else begin
          // Unary escape: k leading zeros (k>=3) then a one codes run k+4 in k+1 bits
          for (int k = 3; k <= 10; k++) begin
            if (!lz_found && bus.Bits[10-k]) begin
              lz_found = 1'b1;
              dec_run  = 4'(k + 4);
              dec_ns   = 4'(k + 1);
            end
          end
          if (!lz_found) dec_bad = 1'b1;
        end
      end
      default: ;
    endcase
    if (dec_run > zl_q) dec_bad = 1'b1;
  end

  // Select between inferred runs (last coefficient, no zeros left) and the table decode
  always_comb begin
    run_c = 4'd0;
    ns_c  = 4'd0;
    err_c = 1'b0;
    if (state_q == S_RUN) begin
      if (last_c) begin
        run_c = zl_q;
      end else if (zl_q != 4'd0) begin
        run_c = dec_run;
        ns_c  = dec_ns;
        err_c = dec_bad;
      end
    end
  end

  assign bus.RunValid  = (state_q == S_RUN) && !err_c;
  assign bus.RunBefore = run_c;
  assign bus.NumShift  = ns_c;
  assign bus.CoeffIdx  = idx_q;
  assign bus.ShiftEn   = bus.RunValid && bus.RunReady && (ns_c != 4'd0);
  assign bus.Busy      = (state_q == S_RUN);
  assign bus.Done      = (state_q == S_DONE);
  assign bus.Error     = (state_q == S_ERR);

  assign accept_c = bus.RunValid && bus.RunReady;
  // The zeros bound is checked as TZ+TC>MAX so no subtraction can wrap
  assign tc_big   = 32'(bus.TotalCoeff) > 32'(MAX_COEFF);
  assign tz_big   = (32'(bus.TotalZeros) + 32'(bus.TotalCoeff)) > 32'(MAX_COEFF);

  // Block sequencing: start validation, per-run bookkeeping, and single-cycle Done/Error pulses
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      tc_q    <= '0;
      zl_q    <= 4'd0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.Start) begin
            tc_q  <= bus.TotalCoeff;
            zl_q  <= bus.TotalZeros;
            idx_q <= '0;
            if ((bus.TotalCoeff == '0) && (bus.TotalZeros == 4'd0)) begin
              state_q <= S_DONE;
            end else if ((bus.TotalCoeff == '0) || tc_big || tz_big) begin
              state_q <= S_ERR;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (err_c) begin
            state_q <= S_ERR;
          end else if (accept_c) begin
            zl_q  <= zl_q - run_c;
            idx_q <= idx_q + ONE;
            if (last_c) state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_before_decoder.sv
// Directed bench for run_before_decoder with a codeword-table reference model and per-cycle output compare.
module tb_run_before_decoder;

  localparam int CW = 5;

  logic Clk;
  logic nReset;
  int   n_chk;
  int   n_err;

  run_before_decoder_if #(.CW(CW)) bus ();

  run_before_decoder #(.MAX_COEFF(16), .CW(CW)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Codeword table: for (zl, run) give code length and value; len 0 means no such codeword
  function automatic void code_of(input int zl, input int r, output int len, output int val);
    len = 0;
    val = 0;
    if (zl >= 7) begin
      if (r <= 6) begin len = 3; val = 7 - r; end
      else if (r <= 14) begin len = r - 3; val = 1; end
    end else begin
      case (zl)
        1: if (r <= 1) begin len = 1; val = 1 - r; end
        2: begin
          if (r == 0) begin len = 1; val = 1; end
          else if (r <= 2) begin len = 2; val = 2 - r; end
        end
        3: if (r <= 3) begin len = 2; val = 3 - r; end
        4: begin
          if (r <= 2) begin len = 2; val = 3 - r; end
          else if (r <= 4) begin len = 3; val = 4 - r; end
        end
        5: begin
          if (r <= 1) begin len = 2; val = 3 - r; end
          else if (r <= 5) begin len = 3; val = 5 - r; end
        end
        6: begin
          case (r)
            0: begin len = 2; val = 3; end
            1: begin len = 3; val = 0; end
            2: begin len = 3; val = 1; end
            3: begin len = 3; val = 3; end
            4: begin len = 3; val = 2; end
            5: begin len = 3; val = 5; end
            6: begin len = 3; val = 4; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  endfunction

  // Prefix match of the window against every codeword of the table
  function automatic void model_decode(input int zl, input logic [10:0] b,
                                       output int run, output int ns, output bit bad);
    int len, val, zlc, w;
    bad = 1'b1;
    run = 0;
    ns  = 0;
    zlc = (zl > 7) ? 7 : zl;
    for (int r = 0; r <= 14; r++) begin
      code_of(zlc, r, len, val);
      if (len > 0 && bad) begin
        w = int'(b >> (11 - len));
        if (w == val) begin
          run = r;
          ns  = len;
          bad = 1'b0;
        end
      end
    end
    if (!bad && run > zl) bad = 1'b1;
  endfunction

  // Reference model of block progress: 0 idle, 1 run, 2 done, 3 error
  int m_phase, m_tc, m_zl, m_idx;

  function automatic void model_expect(output bit v, output int run, output int ns, output bit bad);
    v = 1'b0; run = 0; ns = 0; bad = 1'b0;
    if (m_phase == 1) begin
      if (m_idx == m_tc - 1) run = m_zl;
      else if (m_zl != 0) model_decode(m_zl, bus.Bits, run, ns, bad);
      v = !bad;
    end
  endfunction

  always @(posedge Clk or negedge nReset) begin
    bit v, bad;
    int run, ns, tc, tz;
    if (!nReset) begin
      m_phase <= 0; m_tc <= 0; m_zl <= 0; m_idx <= 0;
    end else begin
      model_expect(v, run, ns, bad);
      case (m_phase)
        0: if (bus.Start) begin
          tc = int'(bus.TotalCoeff);
          tz = int'(bus.TotalZeros);
          m_tc <= tc; m_zl <= tz; m_idx <= 0;
          if (tc == 0 && tz == 0) m_phase <= 2;
          else if (tc == 0 || tc > 16 || tz > 16 - tc) m_phase <= 3;
          else m_phase <= 1;
        end
        1: begin
          if (bad) m_phase <= 3;
          else if (bus.RunReady) begin
            m_zl  <= m_zl - run;
            m_idx <= m_idx + 1;
            if (m_idx == m_tc - 1) m_phase <= 2;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Scoreboard log of accepted runs, shift pulses, valid cycles and Done pulses
  int  acc_run[$];
  int  acc_ns[$];
  int  sh_cnt, vld_cnt, done_cnt;

  always @(negedge Clk) begin
    bit v, bad;
    int run, ns;
    if (!nReset) begin
      chk("rst_RunValid", int'(bus.RunValid), 0);
      chk("rst_Busy", int'(bus.Busy), 0);
      chk("rst_Done", int'(bus.Done), 0);
      chk("rst_Error", int'(bus.Error), 0);
      chk("rst_RunBefore", int'(bus.RunBefore), 0);
      chk("rst_CoeffIdx", int'(bus.CoeffIdx), 0);
      chk("rst_NumShift", int'(bus.NumShift), 0);
    end else begin
      model_expect(v, run, ns, bad);
      chk("RunValid", int'(bus.RunValid), int'(v));
      chk("Busy", int'(bus.Busy), int'(m_phase == 1));
      chk("Done", int'(bus.Done), int'(m_phase == 2));
      chk("Error", int'(bus.Error), int'(m_phase == 3));
      if (v) begin
        chk("RunBefore", int'(bus.RunBefore), run);
        chk("CoeffIdx", int'(bus.CoeffIdx), m_idx);
        chk("NumShift", int'(bus.NumShift), ns);
        chk("ShiftEn", int'(bus.ShiftEn), int'(bus.RunReady && ns != 0));
      end else begin
        chk("ShiftEn_idle", int'(bus.ShiftEn), 0);
      end
      if (bus.RunValid && bus.RunReady) begin
        acc_run.push_back(int'(bus.RunBefore));
        acc_ns.push_back(int'(bus.NumShift));
      end
      if (bus.ShiftEn) sh_cnt++;
      if (bus.RunValid) vld_cnt++;
      if (bus.Done) done_cnt++;
    end
  end

  // One block: bs holds up to four windows, oldest in the top 11 bits; RunReady low for cycles stall_at+1..stall_at+stall_len
  task automatic run_block(input int tc, input int tz, input logic [43:0] bs,
                           input int stall_at, input int stall_len,
                           output int done_cyc, output int err_cyc);
    int idx;
    acc_run.delete();
    acc_ns.delete();
    sh_cnt = 0; vld_cnt = 0;
    done_cyc = -1; err_cyc = -1;
    @(posedge Clk); #1;
    bus.Start      = 1'b1;
    bus.TotalCoeff = tc[CW-1:0];
    bus.TotalZeros = tz[3:0];
    bus.RunReady   = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      idx = acc_run.size();
      bus.Bits = (idx < 4) ? bs[11*(3-idx) +: 11] : 11'h000;
      bus.RunReady = !(c > stall_at && c <= stall_at + stall_len);
      if (bus.Done && done_cyc < 0) done_cyc = c;
      if (bus.Error && err_cyc < 0) err_cyc = c;
      if (done_cyc >= 0 || err_cyc >= 0) break;
    end
    bus.RunReady = 1'b1;
    if (done_cyc < 0 && err_cyc < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL timeout: got no Done/Error expected one within 60 cycles");
    end
  endtask

  // Compare the accepted-run log to a nibble-packed list, first run in the leftmost used nibble
  task automatic check_seq(input string nm, input int n, input logic [63:0] er, input logic [63:0] en);
    chk({nm, "_count"}, acc_run.size(), n);
    for (int i = 0; i < n && i < acc_run.size(); i++) begin
      chk({nm, "_run"}, acc_run[i], int'(er[4*(n-1-i) +: 4]));
      chk({nm, "_ns"}, acc_ns[i], int'(en[4*(n-1-i) +: 4]));
    end
  endtask

  initial begin
    int dc, ec, r, ns;
    bit bad;
    n_chk = 0; n_err = 0; done_cnt = 0;
    nReset = 1'b0;
    bus.Start = 1'b0; bus.TotalCoeff = '0; bus.TotalZeros = 4'd0;
    bus.Bits = 11'h000; bus.RunReady = 1'b1;

    // Pin the reference table with hand-decoded codewords
    model_decode(3, 11'b10000000000, r, ns, bad);
    chk("model_zl3_10", r * 100 + ns, 102);
    model_decode(6, 11'b10100000000, r, ns, bad);
    chk("model_zl6_101", r * 100 + ns, 503);
    model_decode(4, 11'b00000000000, r, ns, bad);
    chk("model_zl4_000", r * 100 + ns, 403);
    model_decode(12, 11'b00000001000, r, ns, bad);
    chk("model_zl12_esc", r * 100 + ns, 1108);
    model_decode(9, 11'b00000000010, r, ns, bad);
    chk("model_zl9_overrun", int'(bad), 1);

    repeat (3) @(posedge Clk);
    #1 nReset = 1'b1;

    // Mixed zl2/zl3 decodes, full rate
    run_block(4, 3, {11'b10000000000, 11'b10000000000, 11'b01000000000, 11'h000}, 99, 0, dc, ec);
    chk("t1_done_cyc", dc, 5);
    chk("t1_shift_cnt", sh_cnt, 3);
    check_seq("t1", 4, 64'h1011, 64'h2120);

    // All zeros consumed early: later runs inferred as zero with no shift
    run_block(5, 2, 44'h0, 99, 0, dc, ec);
    chk("t2_done_cyc", dc, 6);
    chk("t2_shift_cnt", sh_cnt, 1);
    check_seq("t2", 5, 64'h20000, 64'h20000);

    // Unary escape at zl>=7
    run_block(2, 12, {11'b00000001000, 11'h000, 11'h000, 11'h000}, 99, 0, dc, ec);
    chk("t3_done_cyc", dc, 3);
    check_seq("t3", 2, 64'hB1, 64'h80);

    // zl6 and zl1 codewords
    run_block(3, 6, {11'b10100000000, 11'b00000000000, 11'h000, 11'h000}, 99, 0, dc, ec);
    chk("t3b_done_cyc", dc, 4);
    check_seq("t3b", 3, 64'h510, 64'h310);

    // Decoded run exceeds zeros left, then a fresh block is accepted
    run_block(2, 9, {11'b00000000010, 11'h000, 11'h000, 11'h000}, 99, 0, dc, ec);
    chk("t4_err_cyc", ec, 2);
    chk("t4_done_cyc", dc, -1);
    chk("t4_shift_cnt", sh_cnt, 0);
    chk("t4_acc_cnt", acc_run.size(), 0);
    run_block(1, 0, 44'h0, 99, 0, dc, ec);
    chk("t4_restart_done", dc, 2);
    check_seq("t4r", 1, 64'h0, 64'h0);

    // Illegal start: too many zeros for the coefficient count
    run_block(3, 14, 44'h0, 99, 0, dc, ec);
    chk("t4b_err_cyc", ec, 1);

    // Stall three cycles mid-block
    run_block(4, 3, {11'b10000000000, 11'b10000000000, 11'b01000000000, 11'h000}, 2, 3, dc, ec);
    chk("t5_done_cyc", dc, 8);
    chk("t5_shift_cnt", sh_cnt, 3);
    check_seq("t5", 4, 64'h1011, 64'h2120);

    // Reset in the middle of a block
    @(posedge Clk); #1;
    bus.Start = 1'b1; bus.TotalCoeff = 5'd4; bus.TotalZeros = 4'd3; bus.RunReady = 1'b0;
    @(posedge Clk); #1;
    bus.Start = 1'b0; bus.Bits = 11'b10000000000;
    @(posedge Clk); #1;
    chk("t6_busy_before", int'(bus.Busy), 1);
    nReset = 1'b0;
    #2;
    chk("t6_valid_in_rst", int'(bus.RunValid), 0);
    chk("t6_busy_in_rst", int'(bus.Busy), 0);
    @(posedge Clk); #1;
    nReset = 1'b1; bus.RunReady = 1'b1;
    done_cnt = 0;
    repeat (4) @(posedge Clk);
    #1;
    chk("t6_no_done", done_cnt, 0);
    chk("t6_idle", int'(bus.Busy), 0);

    // Empty block
    run_block(0, 0, 44'h0, 99, 0, dc, ec);
    chk("t6_empty_done", dc, 1);
    @(negedge Clk);
    chk("t6_empty_no_valid", vld_cnt, 0);

    repeat (2) @(posedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
